// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled rotate-left / rotate-right / ping-pong / flash
// pattern steered onto one of N_CH colour channels, with a tick strobe for probing.
module led_pattern_gen #(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 32,
    parameter int BASE_COUNT = 2**24,
    parameter int NB_RATE    = 2,
    parameter int N_CH       = 3,
    parameter int NB_CH      = 2
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_RATE-1:0]        i_rate,
    input  logic [1:0]                i_mode,
    input  logic [NB_CH-1:0]          i_ch_sel,
    output logic [N_CH*NB_LEDS-1:0]   o_led,
    output logic                      o_tick,
    output logic                      o_dir
);

    localparam logic [1:0] MODE_ROL   = 2'b00;
    localparam logic [1:0] MODE_ROR   = 2'b01;
    localparam logic [1:0] MODE_PP    = 2'b10;
    localparam logic [1:0] MODE_FLASH = 2'b11;

    logic [NB_COUNTER-1:0] counter;
    logic [NB_COUNTER-1:0] limit;
    logic [NB_LEDS-1:0]    pattern;
    logic [NB_LEDS-1:0]    pattern_nxt;
    logic                  dir;
    logic                  dir_nxt;
    logic [1:0]            mode_q;
    logic                  tick;
    logic                  run_q;
    logic                  mode_chg;
    logic                  tick_due;

    // Rate is sampled every cycle; >= lets a lowered rate fire right away
    // instead of wrapping the counter.
    assign limit    = (NB_COUNTER'(BASE_COUNT) << i_rate) - NB_COUNTER'(1);
    assign tick_due = (counter >= limit);
    assign mode_chg = (i_mode != mode_q);

    // Next pattern and ping-pong direction for the current mode on a tick
    always_comb begin
        pattern_nxt = pattern;
        dir_nxt     = dir;
        case (mode_q)
            MODE_ROL: pattern_nxt = {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
            MODE_ROR: pattern_nxt = {pattern[0], pattern[NB_LEDS-1:1]};
            MODE_PP: begin
                if (!dir) begin
                    pattern_nxt = pattern << 1;
                    if (pattern_nxt[NB_LEDS-1]) dir_nxt = 1'b1;
                end else begin
                    pattern_nxt = pattern >> 1;
                    if (pattern_nxt[0]) dir_nxt = 1'b0;
                end
            end
            MODE_FLASH: pattern_nxt = ~pattern;
            default: pattern_nxt = pattern;
        endcase
    end

    // Prescaler, pattern, direction and mode tracking; a mode change beats a due tick.
    // run_q keeps the LEDs dark until the first edge after reset release.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            counter <= '0;
            pattern <= NB_LEDS'(1);
            dir     <= 1'b0;
            mode_q  <= MODE_ROL;
            tick    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            tick  <= 1'b0;
            if (i_enable) begin
                mode_q <= i_mode;
                if (mode_chg) begin
                    pattern <= (i_mode == MODE_FLASH) ? '0 : NB_LEDS'(1);
                    dir     <= 1'b0;
                    counter <= '0;
                end else if (tick_due) begin
                    pattern <= pattern_nxt;
                    dir     <= dir_nxt;
                    counter <= '0;
                    tick    <= 1'b1;
                end else begin
                    counter <= counter + NB_COUNTER'(1);
                end
            end
        end
    end

    // Steer the pattern to the selected channel; out-of-range selects leave all dark
    always_comb begin
        o_led = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (run_q && (i_ch_sel == NB_CH'(c))) begin
                o_led[c*NB_LEDS +: NB_LEDS] = pattern;
            end
        end
    end

    assign o_tick = tick;
    assign o_dir  = dir;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with BASE_COUNT=4 and hand-computed expectations.
module tb_led_pattern_gen;

    logic        clock;
    logic        i_reset;
    logic        i_enable;
    logic [1:0]  i_rate;
    logic [1:0]  i_mode;
    logic [1:0]  i_ch_sel;
    logic [11:0] o_led;
    logic        o_tick;
    logic        o_dir;

    int total = 0;
    int bad   = 0;

    led_pattern_gen #(
        .NB_LEDS(4), .NB_COUNTER(32), .BASE_COUNT(4),
        .NB_RATE(2), .N_CH(3), .NB_CH(2)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_rate(i_rate), .i_mode(i_mode), .i_ch_sel(i_ch_sel),
        .o_led(o_led), .o_tick(o_tick), .o_dir(o_dir)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Cycles until o_tick is seen, or -1 if the budget runs out
    task automatic wait_tick(input int budget, output int n);
        bit got;
        got = 0;
        n = 0;
        while (!got && n < budget) begin
            step();
            n++;
            if (o_tick) got = 1;
        end
        if (!got) n = -1;
    endtask

    int gap;
    logic [11:0] pp_led [6] = '{12'h002, 12'h004, 12'h008, 12'h004, 12'h002, 12'h001};
    logic        pp_dir [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [11:0] rol_led [4] = '{12'h002, 12'h004, 12'h008, 12'h001};

    initial begin
        i_reset  = 1'b0;
        i_enable = 1'b1;
        i_rate   = 2'd0;
        i_mode   = 2'b00;
        i_ch_sel = 2'd0;
        #1;
        check("rst_led", o_led, 12'h000);
        check("rst_tick", o_tick, 1'b0);
        step();
        step();
        check("rst_led_held", o_led, 12'h000);
        check("rst_dir", o_dir, 1'b0);

        // rotate left on channel 0, period 4
        i_reset = 1'b1;
        step();
        check("rol_first", o_led, 12'h001);
        wait_tick(10, gap);
        check("rol_gap0", gap, 3);
        check("rol_led0", o_led, 12'h002);
        for (int i = 1; i < 4; i++) begin
            wait_tick(10, gap);
            check("rol_gap", gap, 4);
            check("rol_led", o_led, rol_led[i]);
        end

        // ping-pong at rate 1 (period 8)
        i_mode = 2'b10;
        i_rate = 2'd1;
        step();
        check("pp_start_led", o_led, 12'h001);
        check("pp_start_tick", o_tick, 1'b0);
        check("pp_start_dir", o_dir, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wait_tick(20, gap);
            check("pp_gap", gap, 8);
            check("pp_led", o_led, pp_led[i]);
            check("pp_dir", o_dir, pp_dir[i]);
        end

        // flash on channel 2, period 4, then channel steering
        i_mode   = 2'b11;
        i_rate   = 2'd0;
        i_ch_sel = 2'd2;
        step();
        check("fl_start", o_led, 12'h000);
        wait_tick(10, gap);
        check("fl_gap0", gap, 4);
        check("fl_on", o_led, 12'hF00);
        check("fl_dir", o_dir, 1'b0);
        wait_tick(10, gap);
        check("fl_off", o_led, 12'h000);
        wait_tick(10, gap);
        check("fl_on2", o_led, 12'hF00);
        i_ch_sel = 2'd3;
        #1;
        check("ch_oor", o_led, 12'h000);
        i_ch_sel = 2'd1;
        #1;
        check("ch1_led", o_led, 12'h0F0);
        wait_tick(10, gap);
        check("ch1_gap", gap, 4);
        check("ch1_off", o_led, 12'h000);

        // lowering the rate above the new limit fires on the next clock
        i_mode   = 2'b00;
        i_rate   = 2'd3;
        i_ch_sel = 2'd0;
        step();
        check("rate_start", o_led, 12'h001);
        for (int i = 0; i < 20; i++) step();
        check("rate_no_tick", o_tick, 1'b0);
        check("rate_hold_led", o_led, 12'h001);
        i_rate = 2'd0;
        wait_tick(10, gap);
        check("rate_gap1", gap, 1);
        check("rate_led1", o_led, 12'h002);
        wait_tick(10, gap);
        check("rate_gap4", gap, 4);
        check("rate_led2", o_led, 12'h004);

        // mode change while a tick is due: change wins
        step();
        step();
        step();
        i_mode = 2'b01;
        step();
        check("mc_tick", o_tick, 1'b0);
        check("mc_led", o_led, 12'h001);
        wait_tick(10, gap);
        check("mc_gap", gap, 4);
        check("mc_ror", o_led, 12'h008);

        // freeze while disabled mid-count
        step();
        step();
        i_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("frz_tick", o_tick, 1'b0);
            check("frz_led", o_led, 12'h008);
        end
        i_enable = 1'b1;
        wait_tick(10, gap);
        check("frz_gap", gap, 2);
        check("frz_led_after", o_led, 12'h004);

        // asynchronous reset mid-count
        step();
        #2;
        i_reset = 1'b0;
        #1;
        check("arst_led", o_led, 12'h000);
        check("arst_tick", o_tick, 1'b0);
        step();
        check("arst_hold", o_led, 12'h000);
        i_reset = 1'b1;
        step();
        check("arst_restart", o_led, 12'h001);
        wait_tick(10, gap);
        check("arst_gap", gap, 4);
        check("arst_ror", o_led, 12'h008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
